// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline stage with 2-entry skid buffer, branch resolve and overflow trap
module ex_mem_stage #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instruction,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_result,
    input  logic [2:0]      in_flags,
    input  logic [31:0]     in_regB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_alu,
    output logic [31:0]     out_store_data,
    output logic [4:0]      out_dest,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            exc_pending,
    output logic [PC_W-1:0] epc,
    input  logic            exc_ack
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] store_data;
        logic [4:0]  dest;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } entry_t;

    state_t state_q, state_d;

    entry_t dec;
    entry_t out_e;
    entry_t skid_e;
    logic   skid_valid;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [15:0]     imm;
    logic            accept;
    logic            drain;
    logic            is_ovf;
    logic            br_taken;
    logic [PC_W-1:0] br_target;

    // rs, shamt and the negative flag carry no meaning for this stage
    logic unused_bits;
    assign unused_bits = ^{in_instruction[25:21], in_instruction[10:6], in_flags[1]};

    assign opcode = in_instruction[31:26];
    assign funct  = in_instruction[5:0];
    assign rt     = in_instruction[20:16];
    assign rd     = in_instruction[15:11];
    assign imm    = in_instruction[15:0];

    // Only a fully empty skid slot lets a new entry in, so a drain can never collide with a full buffer
    assign in_ready = (state_q == RUN) && !skid_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    // Decode write-back/memory controls, trap condition and branch outcome of the incoming entry
    always_comb begin
        dec            = '0;
        dec.alu        = in_result;
        dec.store_data = in_regB;
        case (opcode)
            6'b000000: begin
                if (funct inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                  6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
                    dec.dest      = rd;
                    dec.reg_write = 1'b1;
                end
            end
            6'b001000, 6'b001001, 6'b001100, 6'b001101,
            6'b001110, 6'b001010, 6'b001011: begin
                dec.dest      = rt;
                dec.reg_write = 1'b1;
            end
            6'b100011: begin
                dec.dest      = rt;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            6'b101011: dec.mem_write = 1'b1;
            default: ;
        endcase

        // Signed add/addi/sub trap; the unsigned variants never do
        is_ovf = in_flags[0] &&
                 (((opcode == 6'b000000) && ((funct == 6'b100000) || (funct == 6'b100010))) ||
                  (opcode == 6'b001000));
        if (is_ovf) begin
            dec.reg_write = 1'b0;
        end

        br_taken  = ((opcode == 6'b000100) &&  in_flags[2]) ||
                    ((opcode == 6'b000101) && !in_flags[2]);
        br_target = in_pc + PC_W'(4) + {{(PC_W-18){imm[15]}}, imm, 2'b00};
    end

    // RUN/HOLD state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD is entered on a trapping accept and left on the first handler acknowledge
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && is_ovf) state_d = HOLD;
            HOLD:    if (exc_ack)          state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign exc_pending = (state_q == HOLD);

    // Output register plus skid entry, kept in strict arrival order
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_e      <= '0;
            skid_valid <= 1'b0;
            skid_e     <= '0;
        end else if (drain) begin
            if (skid_valid) begin
                out_e      <= skid_e;
                skid_valid <= 1'b0;
                out_valid  <= 1'b1;
            end else if (accept) begin
                out_e     <= dec;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid) begin
                out_e     <= dec;
                out_valid <= 1'b1;
            end else begin
                skid_e     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end

    // One-cycle redirect pulse; a trap takes precedence over a branch and records the faulting PC
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            epc            <= '0;
        end else begin
            redirect_valid <= 1'b0;
            if (accept && is_ovf) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= EXC_VECTOR;
                epc            <= in_pc;
            end else if (accept && br_taken) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= br_target;
            end
        end
    end

    assign out_alu        = out_e.alu;
    assign out_store_data = out_e.store_data;
    assign out_dest       = out_e.dest;
    assign out_reg_write  = out_e.reg_write;
    assign out_mem_read   = out_e.mem_read;
    assign out_mem_write  = out_e.mem_write;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM boundary stage of the 5-stage MIPS pipeline; it consumes the ALU's {instruction, result, flags} interface.
- Registers each ALU result and decodes write-back and memory controls from the instruction.
- Resolves beq/bne from the zero flag and raises the overflow exception for add/addi/sub.
- Valid/ready handshake in both directions, with a 2-entry skid buffer so MEM back-pressure never drops an ALU result.

Parameters:
- PC_W, 32, width of the PC and of the branch target.
- EXC_VECTOR, 32'h0000_0080, redirect address on overflow.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  EX presents an entry.
- in_ready  out  1  stage can accept.
- in_instruction  in  32  instruction executed by the ALU.
- in_pc  in  PC_W  PC of that instruction.
- in_result  in  32  ALU result.
- in_flags  in  3  ALU flags: [2] zero, [1] negative, [0] overflow.
- in_regB  in  32  store data.
- out_valid  out  1  entry presented to MEM.
- out_ready  in  1  MEM accepts.
- out_alu  out  32  registered result.
- out_store_data  out  32  registered regB.
- out_dest  out  5  destination register.
- out_reg_write  out  1  write-back enable.
- out_mem_read  out  1  lw.
- out_mem_write  out  1  sw.
- redirect_valid  out  1  one-cycle fetch redirect/flush pulse.
- redirect_pc  out  PC_W  redirect target.
- exc_pending  out  1  overflow exception outstanding.
- epc  out  PC_W  PC of the faulting instruction.
- exc_ack  in  1  exception handler acknowledge.

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - All out_* = 0, redirect_valid = 0, redirect_pc = 0, exc_pending = 0, epc = 0.
  - Skid buffer empty, state = RUN, in_ready = 1 in the cycle after reset.
- Decode fields: opcode = [31:26], funct = [5:0], rt = [20:16], rd = [15:11], imm = [15:0].
- Destination register:
  - R-type (opcode 0): dest = rd. reg_write = 1 for funct add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav.
  - addi, addiu, andi, ori, xori, slti, sltiu, lw: dest = rt, reg_write = 1.
  - beq, bne, sw: reg_write = 0, dest = 0.
  - Unknown opcode or funct: all controls 0, entry still passed through.
- Memory controls: mem_read = (opcode == 100011); mem_write = (opcode == 101011).
- Accept occurs when in_valid & in_ready.
  - in_ready = (state == RUN) & skid buffer not full.
- Storage is an output register plus one skid entry.
  - An accepted entry goes to the output register if it is empty or being drained (out_ready); otherwise it goes to the skid entry.
  - The skid entry moves to the output register on the drain cycle; order is strictly FIFO.
  - Simultaneous accept and drain with both entries full cannot occur, because in_ready = 0 when full.
- Branch resolution (on accept):
  - beq is taken iff flags[2] = 1; bne is taken iff flags[2] = 0.
  - Taken: redirect_valid = 1 in the next cycle for exactly one cycle, with redirect_pc = in_pc + 4 + (sign-extended imm << 2) computed mod 2^PC_W.
  - The branch entry itself still flows to MEM with all controls 0.
- Overflow (on accept): applies when flags[0] = 1 and the instruction is add (funct 100000), addi (001000) or sub (100010).
  - The entry is stored with reg_write forced to 0.
  - Next cycle: epc = in_pc, exc_pending = 1, redirect_valid = 1 with redirect_pc = EXC_VECTOR, and state → HOLD.
  - addu, addiu and subu never trap.
- State machine RUN/HOLD:
  - RUN → HOLD on an overflow accept.
  - HOLD: in_ready = 0; MEM keeps draining; exc_pending stays 1.
  - HOLD → RUN on the first cycle exc_ack = 1; exc_pending clears the same edge.
  - exc_ack in RUN is ignored.
- Branch and exception on the same accept cannot both occur (different opcodes).
  - The exception redirect overrides any in-flight pulse.
- Latency: one cycle from accept to out_valid when the stage is empty. redirect_valid asserts one cycle after accept.
- Reset mid-HOLD or mid-stall discards all entries with no partial output.

Test Plan:
- add regA = 32'h7ffffffe, regB = 2, result 32'h80000000, flags 001, pc = 32'h100 → out_reg_write = 0, next cycle exc_pending = 1, epc = 32'h100, redirect_pc = 32'h80; in_ready = 0 until exc_ack, then 1.
- beq, flags 100, imm = 16'hfffe, pc = 32'h40 → redirect_valid for 1 cycle with redirect_pc = 32'h3c; bne with flags 100 → no redirect.
- Three back-to-back addu with out_ready = 0 → first two accepted, in_ready = 0 on the third; release out_ready → the three outputs arrive in order with dest = rd and reg_write = 1.
- lw rt = 5, result = 5 → out_mem_read = 1, out_dest = 5, out_alu = 5. sw result = -4, regB = 32'hdead → out_mem_write = 1, out_store_data = 32'hdead, reg_write = 0.
- addu with overflow flag 001 → no exception, reg_write = 1.
- Assert reset during HOLD with both entries full → next cycle out_valid = 0, exc_pending = 0, in_ready = 1.
